// File: rtl/sm_to_2comp_pkg.sv
// Shared definitions for the sign-magnitude to two's-complement converter:
// default magnitude width and the control FSM state encoding.
package sm_to_2comp_pkg;

   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      NEG   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/sm_to_2comp_uc.sv
// Control unit: sequences capture, the bit-serial negation and the result
// load; busy and done are pure functions of the state register.
module UC_SM2comp
   import sm_to_2comp_pkg::*;
(
   input  logic clk,
   input  logic RESET,
   input  logic S,
   input  logic trivial,
   input  logic cnt_last,
   output logic capture,
   output logic shift,
   output logic loadres,
   output logic done,
   output logic busy
);

   state_t state_reg;
   state_t state_next;

   always_ff @(posedge clk) begin
      if (!RESET) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      shift      = 1'b0;
      loadres    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (S) begin
               capture    = 1'b1;
               state_next = CHECK;
            end
         end
         CHECK: begin
            // Positive operands and both zeros skip negation entirely
            if (trivial) begin
               loadres    = 1'b1;
               state_next = DONE;
            end else begin
               state_next = NEG;
            end
         end
         NEG: begin
            shift = 1'b1;
            if (cnt_last) begin
               loadres    = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state_reg != IDLE);
   assign done = (state_reg == DONE);

endmodule

// File: rtl/sm_to_2comp.sv
// Sign-magnitude to two's-complement converter: datapath registers plus the
// UC_SM2comp control unit. Negation is ~m + 1, computed LSB first.
module sm_to_2comp
   import sm_to_2comp_pkg::*;
#(
   parameter int N = N_DEFAULT
)
(
   input  logic         clk,
   input  logic         RESET,
   input  logic         S,
   input  logic [N:0]   sm,
   output logic [N:0]   tc,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(N + 1);

   logic          sign_reg;
   logic [N-1:0]  mag_reg;
   logic [N-1:0]  res_reg;
   logic [N-1:0]  res_next;
   logic [CW-1:0] cnt_reg;
   logic          carry_reg;
   logic          carry_next;
   logic          r_bit;
   logic [N:0]    tc_reg;

   logic          capture;
   logic          shift;
   logic          loadres;
   logic          trivial;
   logic          cnt_last;

   assign trivial    = !sign_reg || (mag_reg == '0);
   assign cnt_last   = (cnt_reg == CW'(N - 1));
   assign r_bit      = ~mag_reg[0] ^ carry_reg;
   assign carry_next = ~mag_reg[0] & carry_reg;

   // Each new result bit enters at the MSB so after N steps bit 0 sits at the LSB
   assign res_next[N-1] = r_bit;
   genvar gi;
   generate
      for (gi = 0; gi < N - 1; gi++) begin : g_res_shift
         assign res_next[gi] = res_reg[gi + 1];
      end
   endgenerate

   UC_SM2comp u_uc (
      .clk      (clk),
      .RESET    (RESET),
      .S        (S),
      .trivial  (trivial),
      .cnt_last (cnt_last),
      .capture  (capture),
      .shift    (shift),
      .loadres  (loadres),
      .done     (done),
      .busy     (busy)
   );

   always_ff @(posedge clk) begin
      if (!RESET) begin
         sign_reg  <= 1'b0;
         mag_reg   <= '0;
         res_reg   <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b1;
         tc_reg    <= '0;
      end else begin
         if (capture) begin
            sign_reg  <= sm[N];
            mag_reg   <= sm[N-1:0];
            cnt_reg   <= '0;
            carry_reg <= 1'b1;
         end
         if (shift) begin
            mag_reg   <= mag_reg >> 1;
            res_reg   <= res_next;
            cnt_reg   <= cnt_reg + CW'(1);
            carry_reg <= carry_next;
         end
         if (loadres) begin
            tc_reg <= shift ? {1'b1, res_next} : {1'b0, mag_reg};
         end
      end
   end

   assign tc = tc_reg;

endmodule

// File: doc/sm_to_2comp.md
SM_TO_2COMP -- requirements
Module: sm_to_2comp

Interface
REQ-001 Parameter N, default 4, is the magnitude width; sign-magnitude input and two's-complement output are both N+1 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  reset, synchronous, active-low.
REQ-004 S  input  1  start request, sampled only in IDLE.
REQ-005 sm  input  N+1  sign-magnitude operand; sm[N] is the sign (1 = negative) and sm[N-1:0] is the magnitude.
REQ-006 tc  output  N+1  two's-complement result, registered.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  single-cycle completion pulse; tc is valid from this cycle onward.

Function
REQ-009 FSM states SHALL be IDLE, CHECK, NEG and DONE, with Moore outputs.
REQ-010 In IDLE with S=1, the rising edge SHALL capture sm[N] into a sign register and sm[N-1:0] into a magnitude shift register, clear the bit counter, set carry=1 and enter CHECK.
REQ-011 In IDLE with S=0, the state SHALL be held and tc SHALL keep its last value.
REQ-012 CHECK: if sign=0 or magnitude=0, the next edge SHALL load tc={1'b0, magnitude} and enter DONE; otherwise the next edge SHALL enter NEG.
REQ-013 NEG SHALL be a bit-serial negation over exactly N cycles, LSB first.
REQ-014 Each NEG cycle SHALL compute r = ~m0 XOR carry and carry' = ~m0 AND carry, shift r into the result register from the MSB side, shift the magnitude right and increment the counter.
REQ-015 On the edge where the counter reaches N, NEG SHALL load tc={1'b1, result} and enter DONE.
REQ-016 DONE SHALL assert done=1 for exactly one cycle, and the next edge SHALL enter IDLE.
REQ-017 Latency from the capture edge to done high: 2 cycles for a nonnegative or zero operand; N+2 cycles for a negative nonzero operand.
REQ-018 Negative zero (sm = 1 followed by N zeros) SHALL produce tc=0 via the zero path.
REQ-019 No overflow flag is required: magnitudes 0..2^N-1 always fit in N+1-bit two's complement.
REQ-020 S asserted while busy=1 SHALL be ignored, and sm SHALL NOT be resampled outside the IDLE capture edge.
REQ-021 With S held high continuously, a new capture SHALL occur on the first IDLE edge after DONE, giving a back-to-back period of latency+1 cycles.
REQ-022 tc SHALL change only on entry to DONE or on reset.

Reset
REQ-023 RESET=0 at a rising edge SHALL force the state to IDLE and set tc=0, done=0, busy=0, counter=0, carry=1, and sign and magnitude registers to 0.
REQ-024 Reset SHALL take priority over every transition, including mid-NEG; an in-flight conversion SHALL be discarded without a done pulse.
REQ-025 The first capture SHALL be possible on the first edge with RESET=1 and S=1.

Structure
REQ-026 State encodings and the default N SHALL live in a shared package used by the block and its testbench.
REQ-027 The design SHALL be split into a control unit sub-module, UC_SM2comp, and a datapath in the top module.
REQ-028 UC_SM2comp SHALL hold the FSM and drive the control strobes (capture, shift, loadres, done) to the datapath.
REQ-029 The datapath SHALL hold the sign, magnitude, result, counter and carry registers plus tc.

Verification (N=4)
REQ-030 sm=5'b10011 (-3), S pulsed: busy rises, done pulses 6 cycles after the capture edge, tc=5'b11101.
REQ-031 sm=5'b00101 (+5): done pulses 2 cycles after capture, tc=5'b00101; sm=5'b10000 (-0): done after 2 cycles, tc=5'b00000.
REQ-032 sm=5'b11111 (-15): tc=5'b10001; sm=5'b10001 (-1): tc=5'b11111; each done after 6 cycles.
REQ-033 RESET=0 applied during the third NEG cycle of -3: next cycle is IDLE, tc=0, no done pulse; a subsequent conversion of -3 still yields 5'b11101.
REQ-034 S held high with sm=5'b10011 then changed mid-conversion to 5'b00010: the first done gives tc=5'b11101, the following done gives tc=5'b00010, and the captures are 7 cycles apart.
REQ-035 Exhaustive sweep of all 32 sm values, each compared with a reference (negative nonzero gives 32-magnitude mod 32, everything else gives the magnitude), with zero mismatches.
